// File: rtl/cpu_image_loader_pkg.sv
// Shared types for the CPU image loader: FSM states, command codes and header field layout.
package cpu_image_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD_I = 2'b00,
    CMD_LOAD_D = 2'b01,
    CMD_RUN    = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_t;

  localparam int CMD_MSB = 15;
  localparam int CMD_LSB = 14;
  localparam int CNT_MSB = 11;
  localparam int CNT_LSB = 0;
  localparam int CNT_W   = CNT_MSB - CNT_LSB + 1;

  function automatic cmd_t hdr_cmd(input logic [15:0] hdr);
    return cmd_t'(hdr[CMD_MSB:CMD_LSB]);
  endfunction

endpackage

// File: rtl/loader_res_fifo.sv
// Synchronous result FIFO; push and pop may coincide when full.
module loader_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage needs no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cpu_image_loader.sv
// Loads CPU instruction/data images from a command stream, runs the CPU and captures Out_R.
// Optional run-cycle timeout is enabled by defining LOADER_TIMEOUT_EN.
module cpu_image_loader
  import cpu_image_loader_pkg::*;
#(
  parameter int          RES_DEPTH      = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        ex_iwe,
  output logic        ex_dwe,
  output logic [15:0] ex_iaddr,
  output logic [15:0] ex_idata,
  output logic [15:0] ex_daddr,
  output logic [15:0] ex_ddata,
  output logic        cpu_rst_n,
  input  logic        flag_done,
  input  logic [15:0] Out_R,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        busy,
  output logic [15:0] run_cycles,
  output logic        timeout,
  output logic        res_ovf
);

  state_t            state, state_nxt;
  cmd_t              cmd;
  logic              hdr_load, hdr_run, addr_fire, data_fire;
  logic              run_live, timeout_hit, cap_push, fifo_drop;
  logic              fifo_full, fifo_empty;
  logic              sel_d;
  logic [CNT_W-1:0]  remain;
  logic [15:0]       cur_addr, prev_out_r, run_cycles_inc;

  assign cmd            = hdr_cmd(s_data);
  assign s_ready        = (state != S_RUN);
  assign busy           = !(state == S_IDLE || state == S_DONE);
  assign run_live       = (state == S_RUN) && cpu_rst_n;
  assign run_cycles_inc = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
  assign cap_push       = (state == S_RUN) && (Out_R != 16'd0) && (Out_R != prev_out_r);
  assign fifo_drop      = cap_push && fifo_full && !(m_ready && !fifo_empty);
  assign m_valid        = !fifo_empty;

`ifdef LOADER_TIMEOUT_EN
  assign timeout_hit = run_live && !flag_done && (run_cycles_inc == TIMEOUT_CYCLES);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            timeout <= 1'b0;
    else if (hdr_run)     timeout <= 1'b0;
    else if (timeout_hit) timeout <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    hdr_load  = 1'b0;
    hdr_run   = 1'b0;
    addr_fire = 1'b0;
    data_fire = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (s_valid) begin
          unique case (cmd)
            CMD_LOAD_I, CMD_LOAD_D: begin
              hdr_load  = 1'b1;
              state_nxt = S_ADDR;
            end
            CMD_RUN: begin
              hdr_run   = 1'b1;
              state_nxt = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_ADDR: begin
        if (s_valid) begin
          addr_fire = 1'b1;
          state_nxt = (remain == '0) ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (s_valid) begin
          data_fire = 1'b1;
          if (remain == CNT_W'(1)) state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (run_live && flag_done) state_nxt = S_DONE;
        else if (timeout_hit)      state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_iwe     <= 1'b0;
      ex_dwe     <= 1'b0;
      ex_iaddr   <= '0;
      ex_idata   <= '0;
      ex_daddr   <= '0;
      ex_ddata   <= '0;
      cpu_rst_n  <= 1'b0;
      run_cycles <= '0;
      res_ovf    <= 1'b0;
      sel_d      <= 1'b0;
      remain     <= '0;
      cur_addr   <= '0;
      prev_out_r <= '0;
    end else begin
      ex_iwe     <= 1'b0;
      ex_dwe     <= 1'b0;
      prev_out_r <= Out_R;
      if (hdr_load) begin
        cpu_rst_n <= 1'b0;
        sel_d     <= (cmd == CMD_LOAD_D);
        remain    <= s_data[CNT_MSB:CNT_LSB];
      end
      if (addr_fire) cur_addr <= s_data;
      if (data_fire) begin
        remain   <= remain - CNT_W'(1);
        cur_addr <= cur_addr + 16'd1;
        if (sel_d) begin
          ex_dwe   <= 1'b1;
          ex_daddr <= cur_addr;
          ex_ddata <= s_data;
        end else begin
          ex_iwe   <= 1'b1;
          ex_iaddr <= cur_addr;
          ex_idata <= s_data;
        end
      end
      // A write still on the bus must land before the CPU leaves reset.
      if (hdr_run) begin
        cpu_rst_n  <= !(ex_iwe || ex_dwe);
        run_cycles <= '0;
        res_ovf    <= 1'b0;
      end
      if (state == S_RUN) begin
        if (!cpu_rst_n)     cpu_rst_n  <= 1'b1;
        else if (!flag_done) run_cycles <= run_cycles_inc;
        if (timeout_hit)    cpu_rst_n  <= 1'b0;
      end
      if (fifo_drop) res_ovf <= 1'b1;
    end
  end

  loader_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (16)
  ) u_res_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (hdr_run),
    .push  (cap_push),
    .pop   (m_ready),
    .wdata (Out_R),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
